uex_mutex_ctrl: RTL and testbench

- Hardware mutex controller that shares a bank of N_MUTEX lock resources among N_REQ requesters (cores/threads).
- It is the RTL counterpart of the uex mutex services used by uex threads: it serializes LOCK/TRYLOCK/UNLOCK operations and keeps per-mutex owner and waiter state.
- On unlock it hands ownership off round-robin among blocked waiters.

---
 rtl/uex_hw_pkg.sv | 37 +++
 rtl/uex_rr_arb.sv | 22 ++
 rtl/uex_mutex_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_uex_mutex_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uex_hw_pkg.sv
// Shared types for the uex hardware mutex controller: operation/status codes,
// per-mutex state record and a one-hot to index helper.
package uex_hw_pkg;

    localparam int UEX_MAX_REQ = 16;
    localparam int UEX_OWNER_W = 4;

    typedef enum logic [1:0] {
        LOCK    = 2'd0,
        TRYLOCK = 2'd1,
        UNLOCK  = 2'd2,
        RSVD    = 2'd3
    } uex_mutex_op_e;

    typedef enum logic [1:0] {
        OK   = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } uex_mutex_status_e;

    // Sized for the largest requester count; bits above N_REQ stay zero.
    typedef struct packed {
        logic                   locked;
        logic [UEX_OWNER_W-1:0] owner;
        logic [UEX_MAX_REQ-1:0] waiters;
    } uex_mutex_state_t;

    function automatic logic [UEX_OWNER_W-1:0] uex_onehot_idx(input logic [UEX_MAX_REQ-1:0] vec);
        logic [UEX_OWNER_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < UEX_MAX_REQ; k++) begin
            idx = idx | (vec[k] ? UEX_OWNER_W'(k) : '0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/uex_rr_arb.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at
// or after ptr, wrapping around. ptr must be below N.
module uex_rr_arb #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [N-1:0] rot_req_s;
    logic [N-1:0] rot_gnt_s;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rot_req_s = N'({req, req} >> ptr);
        rot_gnt_s = rot_req_s & ~(rot_req_s - N'(1));
        grant     = N'(({rot_gnt_s, rot_gnt_s} << ptr) >> N);
    end

endmodule

// File: rtl/uex_mutex_ctrl.sv
// Hardware mutex controller: serializes LOCK/TRYLOCK/UNLOCK from N_REQ
// requesters over N_MUTEX locks, with round-robin handoff to blocked waiters.
module uex_mutex_ctrl
    import uex_hw_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int N_MUTEX = 8,
    parameter int ID_W    = (N_MUTEX > 1) ? $clog2(N_MUTEX) : 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [2*N_REQ-1:0]      req_op,
    input  logic [ID_W*N_REQ-1:0]   req_id,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [2*N_REQ-1:0]      rsp_status,
    output logic [N_MUTEX-1:0]      locked
);

    localparam int REQ_IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int MID_W     = (N_MUTEX > 1) ? $clog2(N_MUTEX) : 1;

    uex_mutex_state_t state_r [N_MUTEX];
    logic [REQ_IDX_W-1:0] ptr_r;

    logic [N_REQ-1:0]       blocked_s;
    logic [N_REQ-1:0]       grant_s;
    logic [N_REQ-1:0]       hgrant_s;
    logic                   accept_s;
    logic [1:0]             sel_op_bits_s;
    uex_mutex_op_e          sel_op_s;
    logic [ID_W-1:0]        sel_id_s;
    logic                   id_ok_s;
    logic [MID_W-1:0]       sel_m_s;
    logic [UEX_MAX_REQ-1:0] wait_bit_s;
    logic [UEX_MAX_REQ-1:0] hand_bit_s;
    logic [UEX_OWNER_W-1:0] own_sel_s;
    logic [UEX_OWNER_W-1:0] hand_owner_s;
    logic [REQ_IDX_W-1:0]   sel_req_s;
    logic [REQ_IDX_W-1:0]   ptr_nxt_s;
    logic [REQ_IDX_W-1:0]   hptr_s;
    uex_mutex_state_t       cur_s;
    uex_mutex_state_t       upd_s;
    logic                   is_owner_s;
    logic                   upd_en_s;
    logic                   sel_rsp_s;
    logic                   handoff_s;
    uex_mutex_status_e      sel_status_s;
    logic [N_REQ-1:0]       rsp_valid_nxt_s;
    logic [2*N_REQ-1:0]     rsp_status_nxt_s;

    // A requester is blocked while it sits in any mutex's waiter bitmap.
    always_comb begin
        blocked_s = '0;
        for (int m = 0; m < N_MUTEX; m++) begin
            blocked_s = blocked_s | state_r[m].waiters[N_REQ-1:0];
        end
    end

    uex_rr_arb #(.N(N_REQ), .PW(REQ_IDX_W)) u_req_arb (
        .req   (req_valid & ~blocked_s),
        .ptr   (ptr_r),
        .grant (grant_s)
    );

    // Mux out the granted requester's op and id, and look up its mutex.
    always_comb begin
        req_ready     = grant_s & {N_REQ{reset_n}};
        accept_s      = |(req_valid & req_ready);
        sel_op_bits_s = '0;
        sel_id_s      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sel_op_bits_s = sel_op_bits_s | (req_op[2*k +: 2] & {2{grant_s[k]}});
            sel_id_s      = sel_id_s | (req_id[ID_W*k +: ID_W] & {ID_W{grant_s[k]}});
        end
        sel_op_s   = uex_mutex_op_e'(sel_op_bits_s);
        id_ok_s    = int'(sel_id_s) < N_MUTEX;
        sel_m_s    = id_ok_s ? MID_W'(sel_id_s) : '0;
        cur_s      = state_r[sel_m_s];
        wait_bit_s = UEX_MAX_REQ'(grant_s);
        own_sel_s  = uex_onehot_idx(wait_bit_s);
        sel_req_s  = REQ_IDX_W'(own_sel_s);
        ptr_nxt_s  = REQ_IDX_W'((int'(sel_req_s) + 1) % N_REQ);
        is_owner_s = (cur_s.owner == own_sel_s);
        hptr_s     = REQ_IDX_W'((int'(cur_s.owner) + 1) % N_REQ);
    end

    // Handoff search starts just past the current owner.
    uex_rr_arb #(.N(N_REQ), .PW(REQ_IDX_W)) u_wait_arb (
        .req   (cur_s.waiters[N_REQ-1:0]),
        .ptr   (hptr_s),
        .grant (hgrant_s)
    );

    // Apply the accepted operation to the selected mutex and build responses.
    always_comb begin
        hand_bit_s   = UEX_MAX_REQ'(hgrant_s);
        hand_owner_s = uex_onehot_idx(hand_bit_s);
        upd_s        = cur_s;
        upd_en_s     = 1'b0;
        sel_rsp_s    = 1'b0;
        sel_status_s = OK;
        handoff_s    = 1'b0;
        if (accept_s) begin
            sel_rsp_s = 1'b1;
            case (sel_op_s)
                LOCK: begin
                    if (!id_ok_s) begin
                        sel_status_s = ERR;
                    end else if (!cur_s.locked) begin
                        upd_s.locked = 1'b1;
                        upd_s.owner  = own_sel_s;
                        upd_en_s     = 1'b1;
                    end else if (is_owner_s) begin
                        sel_status_s = ERR;
                    end else begin
                        upd_s.waiters = cur_s.waiters | wait_bit_s;
                        upd_en_s      = 1'b1;
                        sel_rsp_s     = 1'b0;
                    end
                end
                TRYLOCK: begin
                    if (!id_ok_s) begin
                        sel_status_s = ERR;
                    end else if (!cur_s.locked) begin
                        upd_s.locked = 1'b1;
                        upd_s.owner  = own_sel_s;
                        upd_en_s     = 1'b1;
                    end else begin
                        sel_status_s = BUSY;
                    end
                end
                UNLOCK: begin
                    if (id_ok_s && cur_s.locked && is_owner_s) begin
                        upd_en_s = 1'b1;
                        if (|hgrant_s) begin
                            upd_s.owner   = hand_owner_s;
                            upd_s.waiters = cur_s.waiters & ~hand_bit_s;
                            handoff_s     = 1'b1;
                        end else begin
                            upd_s.locked = 1'b0;
                        end
                    end else begin
                        sel_status_s = ERR;
                    end
                end
                default: begin
                    sel_status_s = ERR;
                end
            endcase
        end else begin
            sel_rsp_s = 1'b0;
        end
        rsp_valid_nxt_s = (grant_s & {N_REQ{sel_rsp_s}}) | (hgrant_s & {N_REQ{handoff_s}});
        for (int k = 0; k < N_REQ; k++) begin
            rsp_status_nxt_s[2*k +: 2] = (grant_s[k] && sel_rsp_s) ? sel_status_s : OK;
        end
    end

    // Registered state, pointer and response outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int m = 0; m < N_MUTEX; m++) begin
                state_r[m] <= '0;
            end
            ptr_r      <= '0;
            rsp_valid  <= '0;
            rsp_status <= '0;
            locked     <= '0;
        end else begin
            rsp_valid  <= rsp_valid_nxt_s;
            rsp_status <= rsp_status_nxt_s;
            if (accept_s) begin
                ptr_r <= ptr_nxt_s;
            end
            if (upd_en_s) begin
                state_r[sel_m_s] <= upd_s;
                locked[sel_m_s]  <= upd_s.locked;
            end
        end
    end

endmodule

// File: tb/tb_uex_mutex_ctrl.sv
// Self-checking bench for uex_mutex_ctrl: directed scenarios plus random
// traffic compared against a behavioural mutex model.
module tb_uex_mutex_ctrl;

    localparam int NR = 4;
    localparam int NM = 8;
    localparam int IW = 4;

    logic             clock;
    logic             reset_n;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [2*NR-1:0]  req_op;
    logic [IW*NR-1:0] req_id;
    logic [NR-1:0]    rsp_valid;
    logic [2*NR-1:0]  rsp_status;
    logic [NM-1:0]    locked;

    uex_mutex_ctrl #(.N_REQ(NR), .N_MUTEX(NM), .ID_W(IW)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_id     (req_id),
        .rsp_valid  (rsp_valid),
        .rsp_status (rsp_status),
        .locked     (locked)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: lock flag, owner and waiter set per mutex.
    bit          m_lk  [NM];
    int          m_own [NM];
    bit [NR-1:0] m_wt  [NM];
    int          m_ptr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < NM; m++) begin
            m_lk[m]  = 1'b0;
            m_own[m] = 0;
            m_wt[m]  = '0;
        end
        m_ptr = 0;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = 4'hf;
        req_op    = '0;
        req_id    = '0;
        @(posedge clock);
        @(negedge clock);
        chk("rst_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        @(posedge clock);
        @(negedge clock);
        chk("rst_rsp2", 32'(rsp_valid), 32'd0);
        model_reset();
        reset_n   = 1'b1;
        req_valid = '0;
    endtask

    // One cycle: drive at negedge, check ready, predict, check responses next negedge.
    task automatic run_cycle(input logic [NR-1:0] v, input logic [2*NR-1:0] op, input logic [IW*NR-1:0] id);
        bit [NR-1:0]     blocked;
        logic [NR-1:0]   e_rv;
        logic [2*NR-1:0] e_rs;
        logic [NM-1:0]   e_lk;
        int g, o, d, st, j;
        bit resp;
        req_valid = v;
        req_op    = op;
        req_id    = id;
        #1;
        blocked = '0;
        for (int m = 0; m < NM; m++) blocked |= m_wt[m];
        g = -1;
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (m_ptr + k) % NR;
            if (g < 0 && v[i] && !blocked[i]) g = i;
        end
        chk("ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        e_rv = '0;
        e_rs = '0;
        if (g >= 0) begin
            m_ptr = (g + 1) % NR;
            o     = int'((op >> (2 * g)) & 8'd3);
            d     = int'((id >> (IW * g)) & 16'd15);
            resp  = 1'b1;
            st    = 0;
            if (o == 3 || d >= NM) begin
                st = 2;
            end else if (o == 0 || o == 1) begin
                if (!m_lk[d]) begin
                    m_lk[d]  = 1'b1;
                    m_own[d] = g;
                end else if (o == 1) begin
                    st = 1;
                end else if (m_own[d] == g) begin
                    st = 2;
                end else begin
                    m_wt[d][g] = 1'b1;
                    resp       = 1'b0;
                end
            end else begin
                if (m_lk[d] && m_own[d] == g) begin
                    if (m_wt[d] == '0) begin
                        m_lk[d] = 1'b0;
                    end else begin
                        for (int k = 1; k <= NR; k++) begin
                            j = (m_own[d] + k) % NR;
                            if (m_wt[d][j]) break;
                        end
                        m_own[d]   = j;
                        m_wt[d][j] = 1'b0;
                        e_rv       = e_rv | 4'(1 << j);
                    end
                end else begin
                    st = 2;
                end
            end
            if (resp) begin
                e_rv = e_rv | 4'(1 << g);
                e_rs = e_rs | 8'(st << (2 * g));
            end
        end
        for (int m = 0; m < NM; m++) e_lk[m] = m_lk[m];
        @(posedge clock);
        @(negedge clock);
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        chk("rsp_status", 32'(rsp_status), 32'(e_rs));
        chk("locked", 32'(locked), 32'(e_lk));
    endtask

    task automatic one(input int r, input int o, input int d);
        run_cycle(4'(1 << r), 8'(o << (2 * r)), 16'(d << (IW * r)));
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_id    = '0;
        do_reset();

        // Basic lock/unlock
        one(0, 0, 3);
        chk("t1_lock", 32'(locked), 32'h08);
        one(0, 2, 3);
        chk("t1_unlock", 32'(locked), 32'h00);

        // TRYLOCK busy, blocking LOCK, handoff on unlock
        one(0, 0, 1);
        one(1, 1, 1);
        chk("t2_busy", 32'(rsp_status[3:2]), 32'd1);
        one(1, 0, 1);
        chk("t2_norsp", 32'(rsp_valid), 32'd0);
        run_cycle(4'b0010, 8'h00, 16'h0010);
        one(0, 2, 1);
        chk("t2_handoff", 32'(rsp_valid), 32'h3);
        chk("t2_held", 32'(locked[1]), 32'd1);
        one(1, 2, 1);
        chk("t2_newowner", 32'(rsp_status[3:2]), 32'd0);

        // Fairness: R2 owns id0, R3/R0/R1 wait
        do_reset();
        one(2, 0, 0);
        for (int n = 0; n < 3; n++) run_cycle(4'b1011, 8'h00, 16'h0000);
        one(2, 2, 0);
        chk("t3_to_r3", 32'(rsp_valid), 32'hc);
        one(3, 2, 0);
        chk("t3_to_r0", 32'(rsp_valid), 32'h9);
        one(0, 2, 0);
        chk("t3_to_r1", 32'(rsp_valid), 32'h3);
        one(1, 2, 0);
        chk("t3_free", 32'(locked), 32'h0);

        // All four lock distinct ids together
        do_reset();
        for (int n = 0; n < 4; n++) begin
            run_cycle(4'hf, 8'h00, 16'h3210);
            chk("t4_order", 32'(rsp_valid), 32'd1 << n);
        end
        chk("t4_locked", 32'(locked), 32'h0f);

        // Error cases
        do_reset();
        one(1, 2, 2);
        chk("t5_unl_free", 32'(rsp_status[3:2]), 32'd2);
        one(0, 0, 5);
        one(0, 0, 5);
        chk("t5_relock", 32'(rsp_status[1:0]), 32'd2);
        one(2, 0, 8);
        chk("t5_badid", 32'(rsp_status[5:4]), 32'd2);
        one(3, 3, 0);
        chk("t5_rsvd", 32'(rsp_status[7:6]), 32'd2);

        // Reset with blocked waiters
        do_reset();
        one(0, 0, 4);
        one(1, 0, 4);
        one(2, 0, 4);
        do_reset();
        run_cycle(4'b0000, 8'h00, 16'h0000);
        chk("t6_quiet", 32'(rsp_valid), 32'd0);
        run_cycle(4'b0110, 8'h00, 16'h0440);
        chk("t6_r1_ok", 32'(rsp_valid), 32'h2);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            logic [NR-1:0]    v;
            logic [2*NR-1:0]  op;
            logic [IW*NR-1:0] id;
            if (n % 250 == 0) do_reset();
            v  = 4'($urandom);
            op = '0;
            id = '0;
            for (int r = 0; r < NR; r++) begin
                int w, o, d;
                w = int'($urandom_range(0, 9));
                o = (w < 4) ? 0 : (w < 6) ? 1 : (w < 9) ? 2 : 3;
                d = ($urandom_range(0, 15) == 0) ? 8 : int'($urandom_range(0, 3));
                op = op | 8'(o << (2 * r));
                id = id | 16'(d << (IW * r));
            end
            run_cycle(v, op, id);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
